// File: rtl/somador_serial.sv
// Bit-serial adder: S = A + B, one bit per clock through a single full-adder
// cell and a carry flip-flop. Reports carry-out and signed overflow, and uses
// a start/busy/done handshake to sit beside the serial subtractor in the ULA.
module somador_serial #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Overflow
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      SOMA   = 2'd1,
      FIM    = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_ra;
   logic [WIDTH-1:0] r_rb;
   logic [WIDTH-1:0] r_psum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;

   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;

   logic             w_sbit;
   logic             w_carry_next;
   logic [WIDTH-1:0] w_psum_next;
   logic             w_last;

   // Full-adder cell on the current LSBs plus the sum shift-in path
   always_comb begin
      w_sbit       = r_ra[0] ^ r_rb[0] ^ r_carry;
      w_carry_next = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_carry) | (r_rb[0] & r_carry);
      w_psum_next  = {w_sbit, r_psum[WIDTH-1:1]};
      w_last       = (r_cnt == LAST);
   end

   // Next-state logic: accept start only when idle, finish after bit WIDTH-1
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         OCIOSO:  if (start) w_state_next = SOMA;
         SOMA:    if (w_last) w_state_next = FIM;
         FIM:     w_state_next = OCIOSO;
         default: w_state_next = OCIOSO;
      endcase
   end

   // State register with busy/done registered from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= OCIOSO;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next != OCIOSO);
         r_done  <= (w_state_next == FIM);
      end
   end

   // Operand capture, bit-serial datapath and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ra    <= '0;
         r_rb    <= '0;
         r_psum  <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            OCIOSO: begin
               if (start) begin
                  r_ra    <= A;
                  r_rb    <= B;
                  r_psum  <= '0;
                  r_cnt   <= '0;
                  r_carry <= 1'b0;
               end
            end
            SOMA: begin
               r_ra    <= r_ra >> 1;
               r_rb    <= r_rb >> 1;
               r_psum  <= w_psum_next;
               r_carry <= w_carry_next;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_s    <= w_psum_next;
                  r_cout <= w_carry_next;
                  // On the MSB edge r_carry is exactly the carry into the MSB
                  r_ovf  <= r_carry ^ w_carry_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign S        = r_s;
   assign Cout     = r_cout;
   assign Overflow = r_ovf;

endmodule

// File: tb/tb_somador_serial.sv
// Scoreboarded bench for somador_serial: stimulus pushes the expected result
// and completion cycle; a monitor pops and compares on every done pulse.
module tb_somador_serial;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy;
   logic         done;
   logic [W-1:0] S;
   logic         Cout;
   logic         Overflow;

   int unsigned  checks   = 0;
   int unsigned  failures = 0;
   int unsigned  cyc      = 0;

   typedef struct {
      int unsigned s;
      int unsigned c;
      int unsigned v;
      int unsigned cyc;
   } exp_t;

   exp_t sb[$];

   somador_serial #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .S        (S),
      .Cout     (Cout),
      .Overflow (Overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic on unsigned and signed views
   function automatic exp_t model(input int unsigned a, input int unsigned b,
                                  input int unsigned done_cyc);
      exp_t e;
      int   sa, sb_, ssum;
      int unsigned usum;
      usum = a + b;
      sa   = (a >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
      sb_  = (b >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
      ssum = sa + sb_;
      e.s   = usum % (1 << W);
      e.c   = (usum >= (1 << W)) ? 1 : 0;
      e.v   = (ssum > (1 << (W - 1)) - 1 || ssum < -(1 << (W - 1))) ? 1 : 0;
      e.cyc = done_cyc;
      return e;
   endfunction

   // Called at a negedge while idle; returns one negedge later with start low
   task automatic issue(input int unsigned a, input int unsigned b);
      chk("idle_before_start", int'(busy), 0);
      A     = W'(a);
      B     = W'(b);
      start = 1'b1;
      sb.push_back(model(a, b, cyc + 1 + W));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic add_wait(input int unsigned a, input int unsigned b);
      issue(a, b);
      repeat (W + 1) @(negedge clk);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1, expected no pending result (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("S", int'(S), int'(e.s));
            chk("Cout", int'(Cout), int'(e.c));
            chk("Overflow", int'(Overflow), int'(e.v));
            chk("latency", int'(cyc), int'(e.cyc));
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int unsigned bc;
      int unsigned n0;
      reset = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_S", int'(S), 0);
      chk("rst_Cout", int'(Cout), 0);
      chk("rst_Ovf", int'(Overflow), 0);
      reset = 1'b0;
      @(negedge clk);

      // 4+5 and busy width
      issue(4, 5);
      bc = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy) bc++;
         @(negedge clk);
      end
      chk("busy_cycles", int'(bc), 5);

      add_wait(15, 1);
      add_wait(7, 1);
      add_wait(8, 8);

      // start re-pulsed and operands zeroed mid-operation
      issue(3, 2);
      A     = '0;
      B     = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_after_fim", int'(busy), 0);
      repeat (3) @(negedge clk);

      // reset on the second SOMA edge of 6+6
      issue(6, 6);
      @(negedge clk);
      reset = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_S", int'(S), 0);
      chk("abort_Cout", int'(Cout), 0);
      chk("abort_Ovf", int'(Overflow), 0);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      add_wait(1, 1);

      // start held high: back-to-back 15+15 every W+2 cycles
      n0    = cyc;
      A     = '1;
      B     = '1;
      start = 1'b1;
      for (int k = 0; k < 4; k++)
         sb.push_back(model(15, 15, n0 + 1 + W + (W + 2) * k));
      for (int i = 1; i <= 19; i++) begin
         @(negedge clk);
         if (cyc > n0 + 1 + W && !done) chk("hold_S", int'(S), 14);
      end
      start = 1'b0;
      repeat (6) @(negedge clk);

      // exhaustive operand pairs
      for (int a = 0; a < (1 << W); a++)
         for (int b = 0; b < (1 << W); b++)
            add_wait(a, b);

      // random operands with random idle gaps
      for (int i = 0; i < 100; i++) begin
         issue($urandom_range((1 << W) - 1, 0), $urandom_range((1 << W) - 1, 0));
         repeat (W + 1 + $urandom_range(3, 0)) @(negedge clk);
      end

      repeat (10) @(negedge clk);
      chk("pending_results", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/somador_serial.md
Name: somador_serial

Overview:
Bit-serial adder, the additive counterpart of the team's 4-bit ripple subtractor. It computes S = A + B one bit per clock through a single full-adder cell and a carry flip-flop, and reports carry-out and signed overflow. A start/busy/done handshake lets it sit beside the subtractor in the ULA datapath, and the ULA control FSM sequences it.

Parameters:
WIDTH, 4, operand and result width in bits (must be at least 2)

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new addition; sampled only in state OCIOSO
A  input  WIDTH  operand A, unsigned or two's complement; captured on the accepting edge
B  input  WIDTH  operand B; captured on the accepting edge
busy  output  1  high while the state is SOMA or FIM
done  output  1  one-cycle pulse; high exactly while the state is FIM
S  output  WIDTH  result register A+B mod 2^WIDTH
Cout  output  1  carry out of the MSB (unsigned overflow)
Overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: applied while reset=1 at a rising edge.
  - Values after reset: state=OCIOSO, busy=0, done=0, S=0, Cout=0, Overflow=0, all internal registers=0.
  - Reset overrides start and any operation in progress; an aborted addition produces no done and no result update.
- FSM states: OCIOSO, SOMA, FIM.
- OCIOSO:
  - If start=1 at an edge: capture A and B into shift registers ra and rb, clear carry and the bit counter, clear the partial-sum register, then go to SOMA.
  - If start=0: stay in OCIOSO.
- SOMA: one bit processed per edge, over WIDTH edges.
  - Bit sum: s_bit = ra[0] ^ rb[0] ^ carry.
  - Carry: carry' = majority(ra[0], rb[0], carry).
  - Shifts: ra and rb shift right, and s_bit enters the partial-sum register at its MSB with a right shift. After WIDTH shifts the partial sum is LSB-aligned.
  - The carry into the MSB is saved on the edge that processes bit WIDTH-1.
  - Counter counts 0..WIDTH-1. On the edge that processes bit WIDTH-1:
    - S <= final partial sum
    - Cout <= carry'
    - Overflow <= saved carry into MSB ^ carry'
    - state <= FIM
- FIM: done=1 for exactly one cycle; the next edge returns the state to OCIOSO.
- Latency: let E0 be the edge that accepts start.
  - done is high in the cycle after edge E_WIDTH.
  - S, Cout and Overflow are valid from that same cycle.
  - Minimum start-to-start period is WIDTH+2 cycles (6 for WIDTH=4).
- Output hold: S, Cout and Overflow keep the previous result throughout SOMA and after FIM. They change only at the completing edge or at reset.
- Start during SOMA or FIM is ignored; it is neither queued nor able to corrupt the operation. Changes on A and B after E0 have no effect.
- Start held continuously high gives back-to-back operations, each accepted on the edge after FIM.
- Arithmetic wrap: results are mod 2^WIDTH, with no saturation.
- busy is a registered decode of the state: busy = (state != OCIOSO).

Test Plan:
- Reset, then start with A=4, B=5 -> done pulses for 1 cycle exactly 4 edges after the accept edge; S=9, Cout=0, Overflow=0; busy=1 for 5 cycles.
- A=15, B=1 -> S=0, Cout=1, Overflow=0. Then A=7, B=1 -> S=8, Cout=0, Overflow=1. Then A=8, B=8 -> S=0, Cout=1, Overflow=1.
- Start pulsed again and A, B changed to 0 during SOMA of a 3+2 addition -> result S=5; no extra done; state is OCIOSO one edge after FIM.
- reset=1 on the 2nd SOMA edge of a 6+6 addition -> busy=0, done=0, S=0, Cout=0, Overflow=0 next cycle; done never pulses; a later 1+1 gives S=2.
- start held high with A=15, B=15 -> done pulses every 6 cycles, each with S=14, Cout=1, Overflow=0; S holds 14 between pulses.
- Exhaustive: all 256 A,B pairs, each checking S, Cout and Overflow against a reference model (A+B, signed-overflow rule) and checking the latency of 4 edges.
